// File: rtl/byte_fetch_arbiter.sv
// Shares a byte-wide, one-cycle-latency program memory between instruction fetch
// and data load, assembling four byte reads into a little-endian 32-bit word.
module byte_fetch_arbiter #(
  parameter int ADDRESS_WIDTH  = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int MEM_ADDR_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      if_req,
  input  logic [ADDRESS_WIDTH-1:0]  if_addr,
  output logic                      if_gnt,
  output logic                      if_valid,
  input  logic                      ld_req,
  input  logic [ADDRESS_WIDTH-1:0]  ld_addr,
  output logic                      ld_gnt,
  output logic                      ld_valid,
  output logic [DATA_WIDTH-1:0]     rdata,
  output logic                      mem_rd,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
  input  logic [7:0]                mem_rdata
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;
  typedef enum logic {OWN_IF, OWN_LD} owner_t;

  state_t                    state, state_nxt;
  owner_t                    owner, last_owner;
  logic [1:0]                cnt;
  logic [MEM_ADDR_WIDTH-1:0] base;
  logic                      pick_ld;
  logic                      vld_p1;
  logic [1:0]                lane_p1;
  logic [23:0]               asm_p1;
  logic                      unused_addr_bits;

  assign unused_addr_bits = ^{if_addr[ADDRESS_WIDTH-1:MEM_ADDR_WIDTH],
                              ld_addr[ADDRESS_WIDTH-1:MEM_ADDR_WIDTH]};

  // Round-robin: on contention the requester that did not win last time is picked.
  always_comb begin
    state_nxt = state;
    if_gnt    = 1'b0;
    ld_gnt    = 1'b0;
    if_valid  = 1'b0;
    ld_valid  = 1'b0;
    mem_rd    = 1'b0;
    mem_addr  = '0;
    pick_ld   = ld_req && (!if_req || (last_owner == OWN_IF));
    case (state)
      IDLE: begin
        if (rst_n && (if_req || ld_req)) begin
          if_gnt    = !pick_ld;
          ld_gnt    = pick_ld;
          state_nxt = READ;
        end
      end
      READ: begin
        mem_rd   = 1'b1;
        mem_addr = base + MEM_ADDR_WIDTH'(cnt);
        if (cnt == 2'd3) state_nxt = DRAIN;
      end
      DRAIN: state_nxt = DONE;
      DONE: begin
        if_valid  = (owner == OWN_IF);
        ld_valid  = (owner == OWN_LD);
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p0 -> p1: read strobe and lane index follow the memory's one-cycle latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      owner      <= OWN_IF;
      last_owner <= OWN_LD;
      cnt        <= 2'd0;
      vld_p1     <= 1'b0;
      lane_p1    <= 2'd0;
      rdata      <= '0;
    end else begin
      state   <= state_nxt;
      vld_p1  <= mem_rd;
      lane_p1 <= cnt;
      if (if_gnt || ld_gnt) begin
        owner      <= ld_gnt ? OWN_LD : OWN_IF;
        last_owner <= ld_gnt ? OWN_LD : OWN_IF;
        cnt        <= 2'd0;
      end else if (state == READ) begin
        cnt <= cnt + 2'd1;
      end
      // Lane 3 arrives during DRAIN and is merged straight into rdata on DONE entry.
      if (state == DRAIN) rdata <= {mem_rdata, asm_p1};
    end
  end

  always_ff @(posedge clk) begin
    if (if_gnt)      base <= if_addr[MEM_ADDR_WIDTH-1:0];
    else if (ld_gnt) base <= ld_addr[MEM_ADDR_WIDTH-1:0];
    if (vld_p1) begin
      case (lane_p1)
        2'd0:    asm_p1[7:0]   <= mem_rdata;
        2'd1:    asm_p1[15:8]  <= mem_rdata;
        2'd2:    asm_p1[23:16] <= mem_rdata;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_byte_fetch_arbiter.sv
// Directed bench for byte_fetch_arbiter: a cycle-timing model plus a word scoreboard
// filled at grant time and drained on each valid pulse.
module tb_byte_fetch_arbiter;

  logic        clk;
  logic        rst_n;
  logic        if_req, ld_req;
  logic [31:0] if_addr, ld_addr;
  logic        if_gnt, if_valid, ld_gnt, ld_valid;
  logic [31:0] rdata;
  logic        mem_rd;
  logic [7:0]  mem_addr;
  logic [7:0]  mem_rdata;

  logic [7:0]  mem [256];
  logic [32:0] sbq [$];
  int          passed, total;
  int          since;
  logic        last_ld;
  logic [7:0]  cur_base;
  logic [31:0] exp_rdata;

  byte_fetch_arbiter #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .MEM_ADDR_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_valid(if_valid),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_gnt(ld_gnt), .ld_valid(ld_valid),
    .rdata(rdata), .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (mem_rd) mem_rdata <= mem[mem_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [31:0] word_at(input logic [7:0] b);
    logic [7:0] b1, b2, b3;
    b1 = b + 8'd1;
    b2 = b + 8'd2;
    b3 = b + 8'd3;
    return {mem[b3], mem[b2], mem[b1], mem[b]};
  endfunction

  task automatic cycle();
    logic        elig, exp_if, exp_ld;
    logic [7:0]  a;
    logic [32:0] e;
    @(negedge clk);
    if (since >= 0 && since < 7) since++;
    elig   = (since < 0) || (since >= 7);
    exp_if = elig && if_req && (!ld_req || last_ld);
    exp_ld = elig && ld_req && !exp_if;
    chk("if_gnt", {31'd0, if_gnt}, {31'd0, exp_if});
    chk("ld_gnt", {31'd0, ld_gnt}, {31'd0, exp_ld});
    chk("mem_rd", {31'd0, mem_rd}, {31'd0, (since >= 1 && since <= 4)});
    if (since >= 1 && since <= 4) begin
      a = cur_base + 8'(since - 1);
      chk("mem_addr", {24'd0, mem_addr}, {24'd0, a});
    end
    if (since == 6) begin
      if (sbq.size() == 0) begin
        chk("scoreboard_empty", 32'd0, 32'd1);
        e = '0;
      end else begin
        e = sbq.pop_front();
      end
      exp_rdata = e[31:0];
      chk("if_valid", {31'd0, if_valid}, {31'd0, !e[32]});
      chk("ld_valid", {31'd0, ld_valid}, {31'd0, e[32]});
    end else begin
      chk("if_valid_idle", {31'd0, if_valid}, 32'd0);
      chk("ld_valid_idle", {31'd0, ld_valid}, 32'd0);
    end
    chk("rdata", rdata, exp_rdata);
    if (exp_if || exp_ld) begin
      since    = 0;
      last_ld  = exp_ld;
      cur_base = exp_ld ? ld_addr[7:0] : if_addr[7:0];
      sbq.push_back({exp_ld, word_at(cur_base)});
    end
    @(posedge clk);
    #1;
    if (exp_if) if_req = 1'b0;
    if (exp_ld) ld_req = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    since     = -1;
    last_ld   = 1'b1;
    exp_rdata = '0;
    sbq.delete();
    chk("rst_if_gnt", {31'd0, if_gnt}, 32'd0);
    chk("rst_ld_gnt", {31'd0, ld_gnt}, 32'd0);
    chk("rst_if_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_ld_valid", {31'd0, ld_valid}, 32'd0);
    chk("rst_mem_rd", {31'd0, mem_rd}, 32'd0);
    chk("rst_mem_addr", {24'd0, mem_addr}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    passed  = 0;
    total   = 0;
    since   = -1;
    last_ld = 1'b1;
    if_req  = 1'b0;
    ld_req  = 1'b0;
    if_addr = '0;
    ld_addr = '0;
    rst_n   = 1'b1;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i * 7 + 3);
    #3;
    do_reset();

    // single fetch
    mem[8'h10] = 8'h93; mem[8'h11] = 8'h00; mem[8'h12] = 8'h50; mem[8'h13] = 8'h00;
    if_addr = 32'h0000_0010;
    if_req  = 1'b1;
    run(8);
    chk("fetch_word", rdata, 32'h0050_0093);

    // wrapping load, upper address bits ignored
    mem[8'hFE] = 8'hAA; mem[8'hFF] = 8'hBB; mem[8'h00] = 8'hCC; mem[8'h01] = 8'hDD;
    ld_addr = 32'h0000_01FE;
    ld_req  = 1'b1;
    run(8);
    chk("wrap_word", rdata, 32'hDDCC_BBAA);

    // load raised while a fetch is in flight
    if_req = 1'b1;
    run(2);
    ld_req = 1'b1;
    run(12);
    chk("busy_fetch_then_load", rdata, 32'hDDCC_BBAA);

    // reset during a fetch, with the request re-held
    if_req = 1'b1;
    run(3);
    if_req = 1'b1;
    do_reset();
    run(8);
    chk("after_reset_word", rdata, 32'h0050_0093);

    // back-to-back fetches
    for (int i = 0; i < 8; i++) mem[i] = 8'(8'h11 * (i + 1));
    if_addr = 32'h0;
    if_req  = 1'b1;
    run(1);
    if_addr = 32'h4;
    if_req  = 1'b1;
    run(14);
    chk("b2b_second_word", rdata, 32'h8877_6655);

    // contention from reset: fetch, load, fetch, load
    mem[8'hFE] = 8'hAA; mem[8'hFF] = 8'hBB; mem[8'h00] = 8'hCC; mem[8'h01] = 8'hDD;
    if_addr = 32'h0000_0010;
    ld_addr = 32'h0000_01FE;
    if_req  = 1'b1;
    ld_req  = 1'b1;
    do_reset();
    run(8);
    if_req = 1'b1;
    ld_req = 1'b1;
    run(21);
    chk("contention_last_word", rdata, 32'hDDCC_BBAA);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/byte_fetch_arbiter.md
# byte_fetch_arbiter

Sequences and shares a byte-wide, single-read-port program memory between two 32-bit requesters: the instruction-fetch stage and the data-load path. It wins one requester per transaction and issues four consecutive byte reads. It assembles the bytes little-endian into a 32-bit word and returns that word with a one-cycle valid pulse. It sits between the fetch/load logic and a synchronous byte memory with one-cycle read latency.

## Interface
- ADDRESS_WIDTH, 32, width of requester byte addresses
- DATA_WIDTH, 32, width of the assembled word; fixed at 4 bytes
- MEM_ADDR_WIDTH, 8, memory address width; addresses wrap modulo 2**MEM_ADDR_WIDTH
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request; held high until if_gnt
- if_addr  in  ADDRESS_WIDTH  fetch byte address; sampled on the if_gnt cycle
- if_gnt  out  1  one-cycle pulse: fetch request accepted
- if_valid  out  1  one-cycle pulse: rdata holds the fetch result
- ld_req  in  1  load request; held high until ld_gnt
- ld_addr  in  ADDRESS_WIDTH  load byte address; sampled on the ld_gnt cycle
- ld_gnt  out  1  one-cycle pulse: load request accepted
- ld_valid  out  1  one-cycle pulse: rdata holds the load result
- rdata  out  DATA_WIDTH  assembled word; held until the next completion
- mem_rd  out  1  byte read strobe
- mem_addr  out  MEM_ADDR_WIDTH  byte address for the read
- mem_rdata  in  8  byte returned on the cycle after mem_rd

## Operation
- FSM states: IDLE, READ, DRAIN, DONE.
- IDLE:
  - Either request high → grant exactly one requester (gnt pulse in this cycle).
  - Latch base = addr[MEM_ADDR_WIDTH-1:0] and owner. Upper address bits are ignored.
  - Go to READ with cnt=0.
- Arbitration when both requests are high: round-robin on last_owner.
  - last_owner resets to LOAD, so the first contested grant goes to fetch.
  - A lone request always wins.
- READ:
  - mem_rd=1, mem_addr=base+cnt (wrapping, MEM_ADDR_WIDTH-bit add), cnt increments.
  - After cnt=3 is issued, go to DRAIN.
- Byte capture: a byte is captured into assembly lane k on the cycle after read k is issued.
  - Lane 0 → bits 7:0, lane 1 → 15:8, lane 2 → 23:16, lane 3 → 31:24.
- DRAIN: mem_rd=0; capture lane 3; go to DONE.
- DONE:
  - Load rdata from the assembly register.
  - Pulse the owner's valid (if_valid or ld_valid, never both).
  - Go to IDLE.
- Requests that arrive while not in IDLE are not granted. The requester keeps req high, and it is arbitrated on the next IDLE cycle.
- Misaligned base addresses are legal. The bytes are read from base..base+3 with wrap, e.g. base 0xFE reads 0xFE, 0xFF, 0x00, 0x01.
- Reset (asserted at any time, including mid-transaction):
  - The FSM returns to IDLE at once and the in-flight transaction is dropped; no valid pulse is issued for it.
  - The requester must re-request.

## Timing
- Reset values:
  - if_gnt=0, ld_gnt=0, if_valid=0, ld_valid=0, mem_rd=0.
  - mem_addr=0, rdata=0, cnt=0, last_owner=LOAD, state=IDLE.
- Request accepted in cycle T (IDLE, gnt=1):
  - mem_rd high T+1..T+4 with mem_addr base, base+1, base+2, base+3.
  - mem_rdata bytes arrive T+2..T+5 (T+5 is the DRAIN cycle).
  - Output: rdata is updated at the T+6 edge, and the valid pulse is high for cycle T+6 (DONE).
  - Back in IDLE at T+7; the next grant comes no earlier than T+7.
- Latency: gnt to valid is 6 cycles. Throughput is one word per 7 cycles.
- gnt and valid are registered-free state decodes. gnt is combinational from IDLE and req. valid is a Moore output of DONE.
- rdata changes only on the DONE entry edge.

## Test plan
- Reset, then single fetch:
  - Setup: memory 0x10..0x13 = 93 00 50 00; if_addr=0x10, if_req=1.
  - Expect: if_gnt at T, mem_addr 0x10..0x13 on T+1..T+4, if_valid at T+6 with rdata=0x00500093, ld_valid=0 throughout.
- Contention:
  - Setup: if_req and ld_req both high from reset.
  - Expect: the first grant goes to fetch; ld_gnt follows at the next IDLE, 7 cycles later. Both requests high again → fetch wins the third grant, load the fourth.
- Wrap:
  - Setup: ld_addr=0x0000_01FE (upper bits ignored); memory FE=AA, FF=BB, 00=CC, 01=DD.
  - Expect: mem_addr FE, FF, 00, 01; ld_valid with rdata=0xDDCCBBAA.
- Busy request:
  - Stimulus: raise ld_req at T+2 of a fetch transaction.
  - Expect: no ld_gnt before T+7; ld_gnt at T+7; the fetch result is unaffected.
- Reset mid-operation:
  - Stimulus: assert rst_n low asynchronously at T+3 of a fetch.
  - Expect: outputs return to reset values immediately, no if_valid pulse, rdata=0. After release, a held if_req is granted in the first IDLE cycle.
- Back-to-back same requester:
  - Setup: if_req held high; addresses 0x00, then 0x04.
  - Expect: grants 7 cycles apart; rdata is held stable between the two valid pulses.
